// File: rtl/config_cb_chain_cell_if.sv
// Serial configuration bus for one connection-block cell: shared programming
// controls, the load token in and out, and the 96 decoded switch enables.
interface config_cb_chain_cell_if;
  logic bit_in, prgm_b, cb_prgm_b, cb_prgm_b_in, cb_prgm_b_out;
  logic x1_G0, x1_G1, x1_G2, x1_G3, x1_G4, x1_G5, x1_G6, x1_G7;
  logic x2_G0, x2_G1, x2_G2, x2_G3, x2_G4, x2_G5, x2_G6, x2_G7;
  logic x3_G0, x3_G1, x3_G2, x3_G3, x3_G4, x3_G5, x3_G6, x3_G7;
  logic x4_G0, x4_G1, x4_G2, x4_G3, x4_G4, x4_G5, x4_G6, x4_G7;
  logic x5_G0, x5_G1, x5_G2, x5_G3, x5_G4, x5_G5, x5_G6, x5_G7;
  logic x6_G0, x6_G1, x6_G2, x6_G3, x6_G4, x6_G5, x6_G6, x6_G7;
  logic x7_G0, x7_G1, x7_G2, x7_G3, x7_G4, x7_G5, x7_G6, x7_G7;
  logic x8_G0, x8_G1, x8_G2, x8_G3, x8_G4, x8_G5, x8_G6, x8_G7;
  logic q1_G0, q1_G1, q1_G2, q1_G3, q1_G4, q1_G5, q1_G6, q1_G7;
  logic q2_G0, q2_G1, q2_G2, q2_G3, q2_G4, q2_G5, q2_G6, q2_G7;
  logic q3_G0, q3_G1, q3_G2, q3_G3, q3_G4, q3_G5, q3_G6, q3_G7;
  logic q4_G0, q4_G1, q4_G2, q4_G3, q4_G4, q4_G5, q4_G6, q4_G7;

  // programming controller side
  modport master (
    output bit_in, prgm_b, cb_prgm_b, cb_prgm_b_in,
    input  cb_prgm_b_out,
    input  x1_G0, x1_G1, x1_G2, x1_G3, x1_G4, x1_G5, x1_G6, x1_G7,
    input  x2_G0, x2_G1, x2_G2, x2_G3, x2_G4, x2_G5, x2_G6, x2_G7,
    input  x3_G0, x3_G1, x3_G2, x3_G3, x3_G4, x3_G5, x3_G6, x3_G7,
    input  x4_G0, x4_G1, x4_G2, x4_G3, x4_G4, x4_G5, x4_G6, x4_G7,
    input  x5_G0, x5_G1, x5_G2, x5_G3, x5_G4, x5_G5, x5_G6, x5_G7,
    input  x6_G0, x6_G1, x6_G2, x6_G3, x6_G4, x6_G5, x6_G6, x6_G7,
    input  x7_G0, x7_G1, x7_G2, x7_G3, x7_G4, x7_G5, x7_G6, x7_G7,
    input  x8_G0, x8_G1, x8_G2, x8_G3, x8_G4, x8_G5, x8_G6, x8_G7,
    input  q1_G0, q1_G1, q1_G2, q1_G3, q1_G4, q1_G5, q1_G6, q1_G7,
    input  q2_G0, q2_G1, q2_G2, q2_G3, q2_G4, q2_G5, q2_G6, q2_G7,
    input  q3_G0, q3_G1, q3_G2, q3_G3, q3_G4, q3_G5, q3_G6, q3_G7,
    input  q4_G0, q4_G1, q4_G2, q4_G3, q4_G4, q4_G5, q4_G6, q4_G7
  );

  // configuration cell side
  modport slave (
    input  bit_in, prgm_b, cb_prgm_b, cb_prgm_b_in,
    output cb_prgm_b_out,
    output x1_G0, x1_G1, x1_G2, x1_G3, x1_G4, x1_G5, x1_G6, x1_G7,
    output x2_G0, x2_G1, x2_G2, x2_G3, x2_G4, x2_G5, x2_G6, x2_G7,
    output x3_G0, x3_G1, x3_G2, x3_G3, x3_G4, x3_G5, x3_G6, x3_G7,
    output x4_G0, x4_G1, x4_G2, x4_G3, x4_G4, x4_G5, x4_G6, x4_G7,
    output x5_G0, x5_G1, x5_G2, x5_G3, x5_G4, x5_G5, x5_G6, x5_G7,
    output x6_G0, x6_G1, x6_G2, x6_G3, x6_G4, x6_G5, x6_G6, x6_G7,
    output x7_G0, x7_G1, x7_G2, x7_G3, x7_G4, x7_G5, x7_G6, x7_G7,
    output x8_G0, x8_G1, x8_G2, x8_G3, x8_G4, x8_G5, x8_G6, x8_G7,
    output q1_G0, q1_G1, q1_G2, q1_G3, q1_G4, q1_G5, q1_G6, q1_G7,
    output q2_G0, q2_G1, q2_G2, q2_G3, q2_G4, q2_G5, q2_G6, q2_G7,
    output q3_G0, q3_G1, q3_G2, q3_G3, q3_G4, q3_G5, q3_G6, q3_G7,
    output q4_G0, q4_G1, q4_G2, q4_G3, q4_G4, q4_G5, q4_G6, q4_G7
  );
endinterface

// File: rtl/config_cb_chain_cell.sv
// Connection-block configuration cell: a 96-bit serial shift register that
// loads while it holds the token, then passes the token to the next cell.
module config_cb_chain_cell (
  input logic                  clk,
  input logic                  reset,
  config_cb_chain_cell_if.slave cb
);
  localparam int unsigned CFG_W = 96;

  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_en;

  // Next-state: shift while this cell owns the token, clear the counter when
  // the session ends so the next session reloads from bit 0.
  always_comb begin
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    shift_en = !cb.prgm_b && cb.cb_prgm_b && cb.cb_prgm_b_in && !done_q;
    if (cb.prgm_b) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (shift_en) begin
      cfg_d = {cb.bit_in, cfg_q[CFG_W-1:1]};
      cnt_d = cnt_q + 7'd1;
      if (cnt_q == 7'd95) done_d = 1'b1;
    end
  end

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Token out comes straight from the flop, so chains have no comb path.
  assign cb.cb_prgm_b_out = done_q;

  // Switch G0..G3 of signal s sit in the low half, G4..G7 in the high half.
  assign {cb.x1_G3, cb.x1_G2, cb.x1_G1, cb.x1_G0} = cfg_q[3:0];
  assign {cb.x2_G3, cb.x2_G2, cb.x2_G1, cb.x2_G0} = cfg_q[7:4];
  assign {cb.x3_G3, cb.x3_G2, cb.x3_G1, cb.x3_G0} = cfg_q[11:8];
  assign {cb.x4_G3, cb.x4_G2, cb.x4_G1, cb.x4_G0} = cfg_q[15:12];
  assign {cb.x5_G3, cb.x5_G2, cb.x5_G1, cb.x5_G0} = cfg_q[19:16];
  assign {cb.x6_G3, cb.x6_G2, cb.x6_G1, cb.x6_G0} = cfg_q[23:20];
  assign {cb.x7_G3, cb.x7_G2, cb.x7_G1, cb.x7_G0} = cfg_q[27:24];
  assign {cb.x8_G3, cb.x8_G2, cb.x8_G1, cb.x8_G0} = cfg_q[31:28];
  assign {cb.q1_G3, cb.q1_G2, cb.q1_G1, cb.q1_G0} = cfg_q[35:32];
  assign {cb.q2_G3, cb.q2_G2, cb.q2_G1, cb.q2_G0} = cfg_q[39:36];
  assign {cb.q3_G3, cb.q3_G2, cb.q3_G1, cb.q3_G0} = cfg_q[43:40];
  assign {cb.q4_G3, cb.q4_G2, cb.q4_G1, cb.q4_G0} = cfg_q[47:44];
  assign {cb.x1_G7, cb.x1_G6, cb.x1_G5, cb.x1_G4} = cfg_q[51:48];
  assign {cb.x2_G7, cb.x2_G6, cb.x2_G5, cb.x2_G4} = cfg_q[55:52];
  assign {cb.x3_G7, cb.x3_G6, cb.x3_G5, cb.x3_G4} = cfg_q[59:56];
  assign {cb.x4_G7, cb.x4_G6, cb.x4_G5, cb.x4_G4} = cfg_q[63:60];
  assign {cb.x5_G7, cb.x5_G6, cb.x5_G5, cb.x5_G4} = cfg_q[67:64];
  assign {cb.x6_G7, cb.x6_G6, cb.x6_G5, cb.x6_G4} = cfg_q[71:68];
  assign {cb.x7_G7, cb.x7_G6, cb.x7_G5, cb.x7_G4} = cfg_q[75:72];
  assign {cb.x8_G7, cb.x8_G6, cb.x8_G5, cb.x8_G4} = cfg_q[79:76];
  assign {cb.q1_G7, cb.q1_G6, cb.q1_G5, cb.q1_G4} = cfg_q[83:80];
  assign {cb.q2_G7, cb.q2_G6, cb.q2_G5, cb.q2_G4} = cfg_q[87:84];
  assign {cb.q3_G7, cb.q3_G6, cb.q3_G5, cb.q3_G4} = cfg_q[91:88];
  assign {cb.q4_G7, cb.q4_G6, cb.q4_G5, cb.q4_G4} = cfg_q[95:92];
endmodule

// File: tb/tb_config_cb_chain_cell.sv
// Directed bench for a two-cell configuration chain.
`timescale 1ns/1ps
`define OBS(I) {I.q4_G7,I.q4_G6,I.q4_G5,I.q4_G4,I.q3_G7,I.q3_G6,I.q3_G5,I.q3_G4, \
  I.q2_G7,I.q2_G6,I.q2_G5,I.q2_G4,I.q1_G7,I.q1_G6,I.q1_G5,I.q1_G4, \
  I.x8_G7,I.x8_G6,I.x8_G5,I.x8_G4,I.x7_G7,I.x7_G6,I.x7_G5,I.x7_G4, \
  I.x6_G7,I.x6_G6,I.x6_G5,I.x6_G4,I.x5_G7,I.x5_G6,I.x5_G5,I.x5_G4, \
  I.x4_G7,I.x4_G6,I.x4_G5,I.x4_G4,I.x3_G7,I.x3_G6,I.x3_G5,I.x3_G4, \
  I.x2_G7,I.x2_G6,I.x2_G5,I.x2_G4,I.x1_G7,I.x1_G6,I.x1_G5,I.x1_G4, \
  I.q4_G3,I.q4_G2,I.q4_G1,I.q4_G0,I.q3_G3,I.q3_G2,I.q3_G1,I.q3_G0, \
  I.q2_G3,I.q2_G2,I.q2_G1,I.q2_G0,I.q1_G3,I.q1_G2,I.q1_G1,I.q1_G0, \
  I.x8_G3,I.x8_G2,I.x8_G1,I.x8_G0,I.x7_G3,I.x7_G2,I.x7_G1,I.x7_G0, \
  I.x6_G3,I.x6_G2,I.x6_G1,I.x6_G0,I.x5_G3,I.x5_G2,I.x5_G1,I.x5_G0, \
  I.x4_G3,I.x4_G2,I.x4_G1,I.x4_G0,I.x3_G3,I.x3_G2,I.x3_G1,I.x3_G0, \
  I.x2_G3,I.x2_G2,I.x2_G1,I.x2_G0,I.x1_G3,I.x1_G2,I.x1_G1,I.x1_G0}

module tb_config_cb_chain_cell;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  config_cb_chain_cell_if if0 ();
  config_cb_chain_cell_if if1 ();

  // Second cell shares the serial bus; its token comes from cell 0.
  assign if1.bit_in       = if0.bit_in;
  assign if1.prgm_b       = if0.prgm_b;
  assign if1.cb_prgm_b    = if0.cb_prgm_b;
  assign if1.cb_prgm_b_in = if0.cb_prgm_b_out;

  config_cb_chain_cell u0 (.clk(clk), .reset(rst), .cb(if0));
  config_cb_chain_cell u1 (.clk(clk), .reset(rst), .cb(if1));

  always #5 clk = ~clk;

  logic [95:0] obs0, obs1;
  assign obs0 = `OBS(if0);
  assign obs1 = `OBS(if1);

  localparam logic [95:0] ENDS = 96'h8000_0000_0000_0000_0000_0001;
  localparam logic [95:0] PAT  = 96'hA5C3_0F1E_9B27_6D48_E1F0_3C5A;
  logic [95:0] pv;

  task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    if0.bit_in = b;
    step();
  endtask

  initial begin
    pv = PAT;
    if0.bit_in = 1'b0; if0.prgm_b = 1'b1; if0.cb_prgm_b = 1'b0; if0.cb_prgm_b_in = 1'b1;

    // reset with all controls asserted to show priority
    if0.prgm_b = 1'b0; if0.cb_prgm_b = 1'b1; if0.bit_in = 1'b1;
    rst = 1'b0;
    step();
    chk("reset_cfg0", obs0, 96'h0);
    chk("reset_cfg1", obs1, 96'h0);
    chk("reset_tok0", if0.cb_prgm_b_out, 1'b0);
    chk("reset_tok1", if1.cb_prgm_b_out, 1'b0);
    rst = 1'b1;

    // 192-bit stream: two end-marker patterns, cell 0 then cell 1
    for (int i = 0; i < 95; i++) shift_bit(ENDS[i]);
    chk("tok0_edge95", if0.cb_prgm_b_out, 1'b0);
    shift_bit(ENDS[95]);
    chk("tok0_edge96", if0.cb_prgm_b_out, 1'b1);
    chk("load0_cfg", obs0, ENDS);
    chk("load0_x1_G0", if0.x1_G0, 1'b1);
    chk("load0_q4_G7", if0.q4_G7, 1'b1);
    chk("load0_q4_G3", if0.q4_G3, 1'b0);
    chk("cell1_idle", obs1, 96'h0);
    shift_bit(ENDS[0]);
    chk("cell1_edge97", obs1, 96'h8000_0000_0000_0000_0000_0000);
    for (int i = 1; i < 95; i++) shift_bit(ENDS[i]);
    chk("tok1_edge191", if1.cb_prgm_b_out, 1'b0);
    shift_bit(ENDS[95]);
    chk("tok1_edge192", if1.cb_prgm_b_out, 1'b1);
    chk("chain_cfg1", obs1, ENDS);
    chk("chain_cfg0", obs0, ENDS);

    // bits after both cells are done are not captured
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    chk("extra_cfg0", obs0, ENDS);
    chk("extra_cfg1", obs1, ENDS);

    // session end: config holds, tokens drop
    if0.prgm_b = 1'b1;
    shift_bit(1'b1);
    chk("end_tok0", if0.cb_prgm_b_out, 1'b0);
    chk("end_tok1", if1.cb_prgm_b_out, 1'b0);
    chk("end_hold0", obs0, ENDS);

    // token held low: nothing loads in either cell
    rst = 1'b0; step(); rst = 1'b1;
    if0.prgm_b = 1'b0; if0.cb_prgm_b_in = 1'b0;
    for (int i = 0; i < 200; i++) shift_bit(i[0]);
    chk("toklow_cfg0", obs0, 96'h0);
    chk("toklow_tok0", if0.cb_prgm_b_out, 1'b0);
    chk("toklow_cfg1", obs1, 96'h0);

    // reset mid-load discards the partial configuration
    if0.cb_prgm_b_in = 1'b1;
    for (int i = 0; i < 20; i++) shift_bit(1'b1);
    chk("partial_cfg0", obs0, {20'hFFFFF, 76'h0});
    rst = 1'b0; step(); rst = 1'b1;
    chk("midreset_cfg0", obs0, 96'h0);

    // 40 bits, 10-edge pause with noise on bit_in, then the remaining 56
    for (int i = 0; i < 40; i++) shift_bit(pv[i]);
    if0.cb_prgm_b = 1'b0;
    for (int i = 0; i < 10; i++) shift_bit(~i[0]);
    chk("pause_cfg0", obs0, {pv[39:0], 56'h0});
    if0.cb_prgm_b = 1'b1;
    for (int i = 40; i < 95; i++) shift_bit(pv[i]);
    chk("pause_tok95", if0.cb_prgm_b_out, 1'b0);
    shift_bit(pv[95]);
    chk("pause_tok96", if0.cb_prgm_b_out, 1'b1);
    chk("pause_cfg", obs0, PAT);

    // new session reloads all 96 bits
    if0.prgm_b = 1'b1;
    shift_bit(1'b0);
    chk("reload_hold", obs0, PAT);
    if0.prgm_b = 1'b0;
    for (int i = 0; i < 96; i++) shift_bit(1'b1);
    chk("reload_ones", obs0, {96{1'b1}});
    chk("reload_tok0", if0.cb_prgm_b_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
